dsm_decimator: RTL
==================

Name: dsm_decimator

Overview:
- Receive-side counterpart of the MASH/EFM2 transmit chain.
- Takes the 1-bit delta-sigma bitstream, maps each bit to ±1, and low-pass filters it with an ORDER-stage CIC decimator (ratio R = 2**DECIM_LOG2).
- Emits signed multi-bit samples on an AXI-Stream master.
- Used for loopback verification of the DSM DAC path and as the front end of a 1-bit ADC path.

Parameters:
- ORDER, 3, number of integrator/comb stages (1..5)
- DECIM_LOG2, 6, log2 of decimation ratio R (R = 64)
- OUT_WIDTH, 16, output sample width, must be ≤ ACC_WIDTH
- ACC_WIDTH (localparam), 2+ORDER*DECIM_LOG2, internal two's-complement width (20 at defaults)

Ports:
- aclk  in  1  sole clock
- arst  in  1  asynchronous, active-high reset
- s_axis_data_tdata  in  1  bitstream bit (1 → +1, 0 → −1)
- s_axis_data_tvalid  in  1  bit valid
- s_axis_data_tready  out  1  0 while arst asserted, 1 otherwise (bitstream is never stalled)
- m_axis_data_tdata  out  OUT_WIDTH  signed decimated sample
- m_axis_data_tvalid  out  1  sample valid
- m_axis_data_tready  in  1  downstream accept
- overflow  out  1  sticky, a sample was dropped due to backpressure

Behaviour:
- Reset (async, active-high) clears every register: integrators, combs, decimation counter, output data, m_axis_data_tvalid, overflow. Reset mid-operation discards all partial state; no output is produced until R new beats have been accepted.
- Input beat = s_axis_data_tvalid & s_axis_data_tready. Only beats advance integrators and counter; idle cycles hold all state.
- Integrators: stage0 += sign-extended ±1, stage k += stage k−1 (registered cascade, same edge). Arithmetic is modulo 2**ACC_WIDTH; wrap-around is intended and must not be saturated.
- Decimation counter runs 0..R−1 on beats and wraps. The beat at count R−1 raises dec_strobe (registered).
- Edge after the strobe: the last integrator value is captured into comb input.
- Comb stages are registered: y = x − x_delayed(1 decimated sample), one stage per cycle, each enabled by a delayed strobe.
- m_axis_data_tvalid rises exactly ORDER+2 cycles after the edge that accepted the R-th beat.
- Output = comb result arithmetic-shifted right by ACC_WIDTH−OUT_WIDTH (truncation toward −inf).
- DC gain is R**ORDER; full-scale +1 gives +2**(ACC_WIDTH−2).
- Output handshake: data and valid hold while tvalid & !tready.
  - New result arrives while tvalid & !tready: overwrite data, keep tvalid=1, set overflow (cleared only by reset).
  - New result on the same edge as a completed handshake: load new data, tvalid stays 1, no overflow.
  - Handshake with no new result: tvalid → 0.
- The first ORDER outputs after reset are filter transient; they are not masked.

Optional Feature:
- DSM_DECIMATOR_ROUND_EN defined:
  - Output is round-half-up: add 2**(ACC_WIDTH−OUT_WIDTH−1) before the shift.
  - Saturate to max positive OUT_WIDTH value on positive overflow.
  - One extra pipeline cycle; latency becomes ORDER+3.
- Undefined: plain truncation, latency ORDER+2, no saturation logic.

Decomposition:
- Package dsm_decimator_pkg:
  - function cic_acc_width(order, decim_log2)
  - function bit_to_pm1(bit, width) returning signed ±1
  - localparam defaults ORDER/DECIM_LOG2/OUT_WIDTH
- Sub-module cic_comb_stage (parameter WIDTH; ports aclk, arst, en, x, y): registered differentiator with enable.
  - Instantiated ORDER times via generate.
  - Integrators stay inline.

Test Plan (defaults R=64, ORDER=3, tready=1 unless stated):
- Continuous 1s, beat every cycle → after the 3 transient samples every output = 16384, one output per 64 beats, first tvalid 5 cycles after beat 64.
- Continuous 0s → steady outputs = −16384.
- Alternating 1,0 → steady outputs = 0. Pattern 1,1,1,0 repeated → steady 8192.
- Run 20000 output samples of all 1s → all steady outputs remain 16384 (integrator wrap tolerated), overflow = 0.
- Hold tready=0 across two results → tdata = second result, tvalid = 1, overflow = 1 and stays 1 after tready returns.
- tvalid toggled randomly (50%) with all-1s input → same steady 16384, output spacing tracks beats not cycles. Assert arst mid-stream → all outputs 0 and tready=0 immediately; first new tvalid only after 64 fresh beats.

Source files
------------

// File: rtl/dsm_decimator_pkg.sv
// Shared constants and helpers for the delta-sigma CIC decimator.
package dsm_decimator_pkg;

  localparam int DEFAULT_ORDER      = 3;
  localparam int DEFAULT_DECIM_LOG2 = 6;
  localparam int DEFAULT_OUT_WIDTH  = 16;

  // Width needed to hold R**ORDER * (+/-1) without losing the sign bit,
  // plus one bit of headroom.
  function automatic int cic_acc_width(input int order, input int decim_log2);
    return 2 + order * decim_log2;
  endfunction

  // Maps a bitstream bit to +1 / -1; a target narrower than 2 bits cannot
  // represent both values, so it yields zero instead.
  function automatic logic signed [31:0] bit_to_pm1(input logic b, input int width);
    if (width < 2) begin
      return '0;
    end
    return b ? 32'sd1 : -32'sd1;
  endfunction

  // Half of one output LSB, expressed in accumulator LSBs.
  function automatic int round_offset(input int shift);
    return (shift > 0) ? (1 << (shift - 1)) : 0;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator: y = x - x(previous enabled sample).
module cic_comb_stage
  import dsm_decimator_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] r_xDly;
  logic signed [WIDTH-1:0] r_y;

  assign y = r_y;

  // On each decimated strobe, difference the new input against the last one.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_xDly <= '0;
      r_y    <= '0;
    end else if (en) begin
      r_y    <= x - r_xDly;
      r_xDly <= x;
    end
  end

endmodule

// File: rtl/dsm_decimator.sv
// 1-bit delta-sigma bitstream to multi-bit samples via an ORDER-stage CIC
// decimator (R = 2**DECIM_LOG2), with an AXI-Stream sample output.
// Define DSM_DECIMATOR_ROUND_EN for round-half-up with positive saturation
// (one extra pipeline cycle); otherwise the output is plain truncation.
module dsm_decimator
  import dsm_decimator_pkg::*;
#(
  parameter int ORDER      = DEFAULT_ORDER,
  parameter int DECIM_LOG2 = DEFAULT_DECIM_LOG2,
  parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready,
  output logic                 overflow
);

  localparam int ACC_WIDTH = cic_acc_width(ORDER, DECIM_LOG2);
  localparam int SHIFT     = ACC_WIDTH - OUT_WIDTH;
`ifdef DSM_DECIMATOR_ROUND_EN
  localparam int PIPE      = ORDER + 2;
`else
  localparam int PIPE      = ORDER + 1;
`endif

  logic                        w_beat;
  logic signed [ACC_WIDTH-1:0] w_pm1;
  logic signed [ACC_WIDTH-1:0] r_integ [ORDER];
  logic [DECIM_LOG2-1:0]       r_count;
  logic                        r_strobe;
  logic [PIPE-1:0]             r_stbDly;
  logic signed [ACC_WIDTH-1:0] r_combIn;
  logic signed [ACC_WIDTH-1:0] w_comb [ORDER+1];
  logic [OUT_WIDTH-1:0]        w_result;
  logic                        w_load;
  logic [OUT_WIDTH-1:0]        r_tdata;
  logic                        r_tvalid;
  logic                        r_overflow;

  // The bitstream is never stalled; ready only drops while in reset.
  assign s_axis_data_tready = ~arst;
  assign w_beat             = s_axis_data_tvalid & s_axis_data_tready;
  assign w_pm1              = ACC_WIDTH'(bit_to_pm1(s_axis_data_tdata, ACC_WIDTH));

  // Integrator cascade, advanced only on accepted beats; wraps modulo 2**ACC_WIDTH.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= '0;
      end
    end else if (w_beat) begin
      r_integ[0] <= r_integ[0] + w_pm1;
      for (int k = 1; k < ORDER; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
    end
  end

  // Beat counter; the beat landing on count R-1 raises a one-cycle strobe.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_count  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_beat && (r_count == '1);
      if (w_beat) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Strobe delay line: tap k enables comb stage k, the last tap loads the output.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_stbDly <= '0;
    end else begin
      r_stbDly <= {r_stbDly[PIPE-2:0], r_strobe};
    end
  end

  // Sample the final integrator on the edge after the strobe.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_combIn <= '0;
    end else if (r_strobe) begin
      r_combIn <= r_integ[ORDER-1];
    end
  end

  assign w_comb[0] = r_combIn;

  for (genvar g = 0; g < ORDER; g++) begin : gComb
    cic_comb_stage #(
      .WIDTH (ACC_WIDTH)
    ) uComb (
      .aclk (aclk),
      .arst (arst),
      .en   (r_stbDly[g]),
      .x    (w_comb[g]),
      .y    (w_comb[g+1])
    );
  end

`ifdef DSM_DECIMATOR_ROUND_EN
  localparam int ROUND_ADD = round_offset(SHIFT);

  logic signed [ACC_WIDTH:0] w_sum;
  logic signed [ACC_WIDTH:0] w_shifted;
  logic                      w_posOvf;
  logic [OUT_WIDTH-1:0]      r_rounded;

  assign w_sum     = {w_comb[ORDER][ACC_WIDTH-1], w_comb[ORDER]} + (ACC_WIDTH+1)'(ROUND_ADD);
  assign w_shifted = w_sum >>> SHIFT;
  assign w_posOvf  = !w_shifted[ACC_WIDTH] && (|w_shifted[ACC_WIDTH-1:OUT_WIDTH-1]);

  // Round half up, clamping to the largest positive code if the bump overflows.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_rounded <= '0;
    end else if (r_stbDly[ORDER]) begin
      r_rounded <= w_posOvf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : w_shifted[OUT_WIDTH-1:0];
    end
  end

  assign w_result = r_rounded;
  assign w_load   = r_stbDly[ORDER+1];
`else
  assign w_result = OUT_WIDTH'(w_comb[ORDER] >>> SHIFT);
  assign w_load   = r_stbDly[ORDER];
`endif

  // Output register: holds under backpressure, overwrites and flags a drop
  // if a new sample arrives while the previous one is still unaccepted.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) begin
        r_tdata  <= w_result;
        r_tvalid <= 1'b1;
        if (r_tvalid && !m_axis_data_tready) begin
          r_overflow <= 1'b1;
        end
      end else if (r_tvalid && m_axis_data_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_data_tdata  = r_tdata;
  assign m_axis_data_tvalid = r_tvalid;
  assign overflow           = r_overflow;

endmodule
